i2c_slave_tx: RTL and testbench
===============================

I2C_SLAVE_TX -- requirements
Module: i2c_slave_tx

Interface
REQ-001 Parameter: ADDR_W, 5, local RAM address width (32 bytes).
REQ-002 Parameter: SYNC_STAGES, 2, SCL/SDA input synchronizer depth.
REQ-003 Port: clk  in  1  sole clock; all logic on posedge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: SCL  in  1  raw I2C clock from pad.
REQ-006 Port: SDA_IN  in  1  raw I2C data from pad.
REQ-007 Port: SDA_OE  out  1  open-drain pull-low enable; 1 = drive SDA low, 0 = release.
REQ-008 Port: TX_Start  in  1  one-cycle pulse from the address decoder: read transfer granted, address ACK bit just ended (SCL low).
REQ-009 Port: TX_StartADD  in  ADDR_W  first local RAM address to send; sampled with TX_Start.
REQ-010 Port: LocalRAM_RADD  out  ADDR_W  read address to the RAM controller.
REQ-011 Port: LocalRAM_DOUT  in  8  RAM data; valid one clk after LocalRAM_RADD changes (registered read).
REQ-012 Port: Busy  out  1  high from TX_Start until return to IDLE.
REQ-013 Port: Done  out  1  one-cycle pulse on a normal end of transfer (master NACK).
REQ-014 Port: Aborted  out  1  one-cycle pulse on an end caused by START/STOP or a missing transfer.
REQ-015 Port: BytesSent  out  6  count of bytes ACKed or NACKed in the current or last transfer.

Function
REQ-016 SCL and SDA_IN shall pass through SYNC_STAGES flops; edges are detected on synchronized values (rise/fall flags valid 1 clk).
REQ-017 FSM states shall be IDLE, FETCH, LOAD, SHIFT, ACKWAIT, ACKSAMP.
REQ-018 IDLE: SDA_OE=0; on TX_Start, LocalRAM_RADD<=TX_StartADD, BytesSent<=0, Busy<=1 -> FETCH.
REQ-019 FETCH: 1 clk wait for RAM latency -> LOAD.
REQ-020 LOAD: shift register <= LocalRAM_DOUT, bit counter <= 7, SDA_OE <= ~LocalRAM_DOUT[7] -> SHIFT; completes within 3 clk of TX_Start or of the prior SCL fall.
REQ-021 SHIFT: on each SCL fall, the next lower bit drives SDA_OE (MSB first, SDA_OE = ~bit); after the fall that ends bit 0, SDA_OE<=0 -> ACKWAIT.
REQ-022 ACKWAIT: on SCL rise, sample synchronized SDA; BytesSent increments (saturates at 63); sampled 0 (ACK) -> advance address per REQ-030 -> ACKSAMP(ack); sampled 1 (NACK) -> ACKSAMP(nack).
REQ-023 ACKSAMP(ack): address issued on entry; on SCL fall -> FETCH (SDA_OE=0 until LOAD).
REQ-024 ACKSAMP(nack): on SCL fall -> IDLE, Done pulse, Busy<=0.
REQ-025 START or STOP (SDA edge while synchronized SCL high) in any non-IDLE state except while SDA_OE=1 shall force IDLE in the next clk: SDA_OE=0, Aborted pulse, Busy<=0.
REQ-026 TX_Start while Busy shall be ignored.
REQ-027 Data bits shall change only after an SCL fall, never while SCL is high; the block shall tolerate SCL low periods of at least 4 clk.
REQ-028 BytesSent shall hold its value in IDLE until the next TX_Start.

Reset
REQ-029 Reset asserted (asynchronous, any state, including mid-byte) shall immediately set SDA_OE=0, LocalRAM_RADD=0, Busy=0, Done=0, Aborted=0, BytesSent=0, shift register=0, state=IDLE; synchronizer flops reset to 1 (bus idle).

Configuration
REQ-030 Macro I2C_SLAVE_TX_AUTOWRAP_EN: defined -> address increments modulo 2^ADDR_W (31->0); undefined -> address saturates at 31, and every byte after the one at address 31 is sent as 8'hFF (SDA released) without a RAM read.

Verification
REQ-031 TX_StartADD=3, RAM[3]=8'hA5, master NACKs -> SDA sequence 1,0,1,0,0,1,0,1; Done pulse; BytesSent=1; LocalRAM_RADD=3.
REQ-032 TX_StartADD=0, master ACKs 2 bytes then NACKs the 3rd -> bytes RAM[0],RAM[1],RAM[2]; BytesSent=3; Done once.
REQ-033 TX_StartADD=31, ACK then NACK: with macro -> RAM[31], RAM[0]; without -> RAM[31], 8'hFF; LocalRAM_RADD stays 31.
REQ-034 STOP injected after bit 4 of a byte with bit 4 = 1 -> next clk IDLE, SDA_OE=0, Aborted pulse, Done=0.
REQ-035 Reset pulsed while SDA_OE=1 mid-byte -> SDA_OE=0 in the same clk without waiting for a clock edge; all outputs at reset values; a later TX_Start operates normally.
REQ-036 A second TX_Start during byte 1 -> ignored; address and bit sequence unchanged.

Source files
------------

// File: rtl/i2c_slave_tx_if.sv
// i2c_slave_tx_if: pad, RAM-read and status signals of the I2C slave transmit engine.
interface i2c_slave_tx_if #(
    parameter int ADDR_W = 5
);
    logic              SCL;
    logic              SDA_IN;
    logic              SDA_OE;
    logic              TX_Start;
    logic [ADDR_W-1:0] TX_StartADD;
    logic [ADDR_W-1:0] LocalRAM_RADD;
    logic [7:0]        LocalRAM_DOUT;
    logic              Busy;
    logic              Done;
    logic              Aborted;
    logic [5:0]        BytesSent;

    modport slave (
        input  SCL, SDA_IN, TX_Start, TX_StartADD, LocalRAM_DOUT,
        output SDA_OE, LocalRAM_RADD, Busy, Done, Aborted, BytesSent
    );

    modport master (
        output SCL, SDA_IN, TX_Start, TX_StartADD, LocalRAM_DOUT,
        input  SDA_OE, LocalRAM_RADD, Busy, Done, Aborted, BytesSent
    );
endinterface

// File: rtl/i2c_slave_tx.sv
// i2c_slave_tx: I2C slave read-transfer engine streaming local RAM bytes onto SDA.
// Define I2C_SLAVE_TX_AUTOWRAP_EN to wrap the RAM address; otherwise it saturates and pads with 8'hFF.
module i2c_slave_tx #(
    parameter int ADDR_W      = 5,
    parameter int SYNC_STAGES = 2
) (
    input logic           clk,
    input logic           reset,
    i2c_slave_tx_if.slave bus
);
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHIFT, ACKWAIT, ACKSAMP} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [7:0]             shreg_q, shreg_d;
    logic [2:0]             bitcnt_q, bitcnt_d;
    logic [5:0]             sent_q, sent_d;
    logic                   sda_oe_q, sda_oe_d, busy_q, busy_d;
    logic                   done_q, done_d, aborted_q, aborted_d;
    logic                   ack_q, ack_d, past_end_q, past_end_d;
    logic                   scl_s, sda_s, scl_rise, scl_fall, bus_cond;

    assign scl_s    = scl_sync_q[SYNC_STAGES-1];
    assign sda_s    = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_prev_q;
    assign scl_fall = ~scl_s & scl_prev_q;
    // START/STOP: any data edge while the clock is high
    assign bus_cond = scl_s & (sda_s ^ sda_prev_q);

    always_comb begin
        scl_sync_d = (scl_sync_q << 1) | SYNC_STAGES'(bus.SCL);
        sda_sync_d = (sda_sync_q << 1) | SYNC_STAGES'(bus.SDA_IN);
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
        state_d    = state_q;
        addr_d     = addr_q;
        shreg_d    = shreg_q;
        bitcnt_d   = bitcnt_q;
        sent_d     = sent_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        ack_d      = ack_q;
        past_end_d = past_end_q;
        done_d     = 1'b0;
        aborted_d  = 1'b0;
        // our own pull-low cannot be mistaken for a master START/STOP
        if (state_q != IDLE && !sda_oe_q && bus_cond) begin
            state_d   = IDLE;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            aborted_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: if (bus.TX_Start) begin
                    addr_d     = bus.TX_StartADD;
                    sent_d     = '0;
                    busy_d     = 1'b1;
                    past_end_d = 1'b0;
                    state_d    = FETCH;
                end
                FETCH: state_d = LOAD;
                LOAD: begin
                    shreg_d  = past_end_q ? 8'hFF : bus.LocalRAM_DOUT;
                    bitcnt_d = 3'd7;
                    sda_oe_d = ~shreg_d[7];
                    state_d  = SHIFT;
                end
                SHIFT: if (scl_fall) begin
                    if (bitcnt_q == 3'd0) begin
                        sda_oe_d = 1'b0;
                        state_d  = ACKWAIT;
                    end else begin
                        sda_oe_d = ~shreg_q[6];
                        shreg_d  = {shreg_q[6:0], 1'b0};
                        bitcnt_d = bitcnt_q - 3'd1;
                    end
                end
                ACKWAIT: if (scl_rise) begin
                    sent_d  = (sent_q == 6'd63) ? sent_q : sent_q + 6'd1;
                    ack_d   = ~sda_s;
                    state_d = ACKSAMP;
                    if (!sda_s) begin
`ifdef I2C_SLAVE_TX_AUTOWRAP_EN
                        addr_d = addr_q + ADDR_W'(1);
`else
                        if (&addr_q) past_end_d = 1'b1;
                        else addr_d = addr_q + ADDR_W'(1);
`endif
                    end
                end
                ACKSAMP: if (scl_fall) begin
                    state_d = ack_q ? FETCH : IDLE;
                    done_d  = ~ack_q;
                    busy_d  = ack_q;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= IDLE;
            addr_q     <= '0;
            shreg_q    <= '0;
            bitcnt_q   <= '0;
            sent_q     <= '0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            ack_q      <= 1'b0;
            past_end_q <= 1'b0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
            state_q    <= state_d;
            addr_q     <= addr_d;
            shreg_q    <= shreg_d;
            bitcnt_q   <= bitcnt_d;
            sent_q     <= sent_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
            ack_q      <= ack_d;
            past_end_q <= past_end_d;
        end
    end

    assign bus.SDA_OE        = sda_oe_q;
    assign bus.LocalRAM_RADD = addr_q;
    assign bus.Busy          = busy_q;
    assign bus.Done          = done_q;
    assign bus.Aborted       = aborted_q;
    assign bus.BytesSent     = sent_q;
endmodule

// File: tb/tb_i2c_slave_tx.sv
// tb_i2c_slave_tx: bit-banged I2C master plus RAM model exercising read transfers, aborts and reset.
module tb_i2c_slave_tx;
    localparam int AW   = 5;
    localparam int LOW  = 10;
    localparam int HIGH = 10;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       m_sda = 1'b1;
    logic [7:0] ram [1 << AW];
    int         checks = 0, errors = 0, done_cnt = 0, abort_cnt = 0;

    i2c_slave_tx_if #(.ADDR_W(AW)) bus ();
    i2c_slave_tx #(.ADDR_W(AW), .SYNC_STAGES(2)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;
    assign bus.SDA_IN = m_sda & ~bus.SDA_OE;
    always @(posedge clk) bus.LocalRAM_DOUT <= ram[bus.LocalRAM_RADD];

    always @(negedge clk) begin
        if (bus.Done) done_cnt++;
        if (bus.Aborted) abort_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // k-th byte of a transfer starting at address a
    function automatic logic [7:0] exp_byte(input int a, input int k);
`ifdef I2C_SLAVE_TX_AUTOWRAP_EN
        return ram[(a + k) % (1 << AW)];
`else
        return (a + k > (1 << AW) - 1) ? 8'hFF : ram[a + k];
`endif
    endfunction

    function automatic int exp_radd(input int a, input int acks);
`ifdef I2C_SLAVE_TX_AUTOWRAP_EN
        return (a + acks) % (1 << AW);
`else
        return (a + acks > (1 << AW) - 1) ? (1 << AW) - 1 : a + acks;
`endif
    endfunction

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_xfer(input int a);
        bus.SCL = 1'b0;
        clks(5);
        bus.TX_StartADD = AW'(a);
        bus.TX_Start = 1'b1;
        clks(1);
        bus.TX_Start = 1'b0;
    endtask

    task automatic read_byte(input logic [7:0] exp, input string tag, input int spur);
        logic [7:0] got;
        logic s1, s2;
        for (int i = 7; i >= 0; i--) begin
            clks(LOW);
            if (i == 3 && spur >= 0) begin
                bus.TX_StartADD = AW'(spur);
                bus.TX_Start = 1'b1;
                clks(1);
                bus.TX_Start = 1'b0;
            end
            bus.SCL = 1'b1;
            clks(HIGH / 2);
            s1 = bus.SDA_IN;
            clks(HIGH / 2);
            s2 = bus.SDA_IN;
            bus.SCL = 1'b0;
            chk({tag, " sda_stable_high"}, 32'(s2), 32'(s1));
            got[i] = s1;
        end
        chk({tag, " byte"}, 32'(got), 32'(exp));
    endtask

    task automatic ack_bit(input logic nack);
        clks(2);
        m_sda = nack;
        clks(LOW - 2);
        bus.SCL = 1'b1;
        clks(HIGH);
        bus.SCL = 1'b0;
        clks(2);
        m_sda = 1'b1;
    endtask

    task automatic stop_cond();
        clks(4);
        m_sda = 1'b0;
        clks(4);
        bus.SCL = 1'b1;
        clks(4);
        m_sda = 1'b1;
        clks(4);
    endtask

    task automatic xfer(input int a, input int n, input int spur, input string tag);
        int d0, a0;
        d0 = done_cnt;
        a0 = abort_cnt;
        start_xfer(a);
        clks(4);
        chk({tag, " busy_on"}, 32'(bus.Busy), 1);
        for (int k = 0; k < n; k++) begin
            read_byte(exp_byte(a, k), tag, (k == 0) ? spur : -1);
            ack_bit(k == n - 1);
        end
        stop_cond();
        chk({tag, " busy_off"}, 32'(bus.Busy), 0);
        chk({tag, " bytes_sent"}, 32'(bus.BytesSent), (n > 63) ? 63 : n);
        chk({tag, " radd"}, 32'(bus.LocalRAM_RADD), exp_radd(a, n - 1));
        chk({tag, " done_pulses"}, done_cnt - d0, 1);
        chk({tag, " abort_pulses"}, abort_cnt - a0, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " sda_oe"}, 32'(bus.SDA_OE), 0);
        chk({tag, " radd"}, 32'(bus.LocalRAM_RADD), 0);
        chk({tag, " busy"}, 32'(bus.Busy), 0);
        chk({tag, " done"}, 32'(bus.Done), 0);
        chk({tag, " aborted"}, 32'(bus.Aborted), 0);
        chk({tag, " bytes_sent"}, 32'(bus.BytesSent), 0);
    endtask

    initial begin
        int a, d0, a0;
        bus.SCL = 1'b1;
        bus.TX_Start = 1'b0;
        bus.TX_StartADD = '0;
        foreach (ram[i]) ram[i] = 8'($urandom);
        clks(3);
        chk_reset_vals("reset");
        reset = 1'b0;
        clks(5);

        ram[3] = 8'hA5;
        xfer(3, 1, -1, "single_nack");
        xfer(0, 3, -1, "three_bytes");
        xfer(31, 2, -1, "top_addr");
        repeat (6) xfer(int'($urandom_range(0, 31)), int'($urandom_range(1, 4)), -1, "random");

        a = int'($urandom_range(0, 31));
        xfer(a, 2, (a + 7) % 32, "ignored_start");

        // STOP while bit 4 (a released 1) is on the bus
        a = int'($urandom_range(0, 31));
        ram[a] = ram[a] | 8'h10;
        d0 = done_cnt;
        a0 = abort_cnt;
        start_xfer(a);
        for (int i = 7; i > 4; i--) begin
            clks(LOW);
            bus.SCL = 1'b1;
            clks(HIGH);
            bus.SCL = 1'b0;
        end
        clks(LOW);
        chk("stop bit4_released", 32'(bus.SDA_OE), 0);
        m_sda = 1'b0;
        clks(2);
        bus.SCL = 1'b1;
        clks(4);
        m_sda = 1'b1;
        clks(4);
        chk("stop abort_pulses", abort_cnt - a0, 1);
        chk("stop done_pulses", done_cnt - d0, 0);
        chk("stop busy", 32'(bus.Busy), 0);
        chk("stop sda_oe", 32'(bus.SDA_OE), 0);

        // asynchronous reset while pulling SDA low mid-byte
        a = int'($urandom_range(1, 31));
        ram[a] = ram[a] & 8'h7F;
        start_xfer(a);
        clks(LOW);
        chk("midbyte sda_oe_before", 32'(bus.SDA_OE), 1);
        #2 reset = 1'b1;
        #1 chk_reset_vals("async_reset");
        bus.SCL = 1'b1;
        m_sda = 1'b1;
        clks(3);
        reset = 1'b0;
        clks(5);
        xfer(int'($urandom_range(0, 31)), 2, -1, "after_reset");

        xfer(int'($urandom_range(0, 31)), 65, -1, "saturate63");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
